// File: rtl/ifmap_fetch_ctrl_if.sv
// AXI read channel plus input-buffer write port of the ifmap fetch controller.
interface ifmap_fetch_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int CW = 5
);
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [1:0]    arburst;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic          wr_en;
    logic [7:0]    wr_bank;
    logic [CW-1:0] wr_col;
    logic [DW-1:0] wr_data;
    logic          blkend;
    logic          mapend;

    modport master (
        output arvalid, araddr, arlen, arburst, rready,
        output wr_en, wr_bank, wr_col, wr_data, blkend, mapend,
        input  arready, rvalid, rdata, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arburst, rready,
        input  wr_en, wr_bank, wr_col, wr_data, blkend, mapend,
        output arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/ifmap_fetch_ctrl.sv
// Walks the input feature map tile by tile, one INCR burst per tile row, into the input buffer.
// Optional FETCH_PERF_EN adds a saturating stall_cnt output.
module ifmap_fetch_ctrl #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int KSIZE  = 3,
    parameter int POX    = 15,
    parameter int POY    = 3,
    parameter int STRIDE = 2,
    parameter int IW     = 224,
    parameter int IH     = 224,
    parameter int BURST  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_load,
    input  logic               init_addr_en,
    input  logic [AW-1:0]      init_addr,
    ifmap_fetch_ctrl_if.master bus,
    output logic               protocol_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);
    localparam int TR    = (POY - 1) * STRIDE + KSIZE;
    localparam int CSTEP = POX * STRIDE;
    localparam int RSTEP = POY * STRIDE;
    localparam int NTX   = (IW + CSTEP - 1) / CSTEP;
    localparam int NTY   = (IH + RSTEP - 1) / RSTEP;
    localparam int B     = DW / 8;
    localparam int CW    = $clog2(BURST);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_DATA, S_ZFILL, S_NEXT, S_HOLD
    } state_t;

    state_t        state_r;
    logic [AW-1:0] base_r;
    logic [15:0]   tx_r;
    logic [15:0]   ty_r;
    logic [7:0]    r_r;
    logic [CW-1:0] beat_r;
    logic          drop_r;
    logic          dl_prev_r;
    logic          arvalid_r;
    logic [AW-1:0] araddr_r;
    logic          rready_r;
    logic          wr_en_r;
    logic [7:0]    wr_bank_r;
    logic [CW-1:0] wr_col_r;
    logic [DW-1:0] wr_data_r;
    logic          blkend_r;
    logic          mapend_r;
    logic          perr_r;

    logic [7:0]    r_nxt_s;
    logic          row_done_s;
    logic          beat_last_s;
    logic          tx_last_s;
    logic          ty_last_s;
    logic          col_zero_s;
    logic          init_ok_s;

    function automatic logic [AW-1:0] row_addr_f(input logic [AW-1:0] base, input logic [15:0] tx,
                                                 input logic [15:0] ty, input logic [7:0] r);
        logic [AW-1:0] row_w;
        logic [AW-1:0] word_w;
        row_w  = AW'(ty) * AW'(RSTEP) + AW'(r);
        word_w = row_w * AW'(IW) + AW'(tx) * AW'(CSTEP);
        return base + word_w * AW'(B);
    endfunction

    function automatic logic row_in_map_f(input logic [15:0] ty, input logic [7:0] r);
        return (32'(ty) * 32'(RSTEP) + 32'(r)) < 32'(IH);
    endfunction

    assign r_nxt_s     = r_r + 8'd1;
    assign row_done_s  = (r_nxt_s == 8'(TR));
    assign beat_last_s = (beat_r == CW'(BURST - 1));
    assign tx_last_s   = (tx_r == 16'(NTX - 1));
    assign ty_last_s   = (ty_r == 16'(NTY - 1));
    // Beats past the right map edge are written as zero padding.
    assign col_zero_s  = (32'(tx_r) * 32'(CSTEP) + 32'(beat_r)) >= 32'(IW);
    assign init_ok_s   = init_addr_en && ((state_r == S_IDLE) || (state_r == S_HOLD));

    // Tile walker FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            base_r    <= '0;
            tx_r      <= 16'd0;
            ty_r      <= 16'd0;
            r_r       <= 8'd0;
            beat_r    <= '0;
            drop_r    <= 1'b0;
            dl_prev_r <= 1'b0;
            arvalid_r <= 1'b0;
            araddr_r  <= '0;
            rready_r  <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_bank_r <= 8'd0;
            wr_col_r  <= '0;
            wr_data_r <= '0;
            blkend_r  <= 1'b0;
            mapend_r  <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            dl_prev_r <= data_load;
            wr_en_r   <= 1'b0;
            blkend_r  <= 1'b0;
            mapend_r  <= 1'b0;
            if (init_ok_s) begin
                base_r <= init_addr;
                tx_r   <= 16'd0;
                ty_r   <= 16'd0;
                perr_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    state_r <= data_load ? S_START : S_IDLE;
                end
                S_START: begin
                    r_r    <= 8'd0;
                    beat_r <= '0;
                    if (row_in_map_f(ty_r, 8'd0)) begin
                        araddr_r  <= row_addr_f(base_r, tx_r, ty_r, 8'd0);
                        arvalid_r <= 1'b1;
                        state_r   <= S_ADDR;
                    end else begin
                        state_r <= S_ZFILL;
                    end
                end
                S_ADDR: begin
                    if (bus.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        drop_r    <= 1'b0;
                        state_r   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.rvalid && drop_r) begin
                        if (bus.rlast) begin
                            rready_r <= 1'b0;
                            state_r  <= S_NEXT;
                        end
                    end else if (bus.rvalid) begin
                        wr_en_r   <= 1'b1;
                        wr_bank_r <= r_r;
                        wr_col_r  <= beat_r;
                        wr_data_r <= col_zero_s ? '0 : bus.rdata;
                        if (beat_last_s) begin
                            if (bus.rlast) begin
                                rready_r <= 1'b0;
                                state_r  <= S_NEXT;
                            end else begin
                                // Overlong burst: swallow the excess beats until rlast.
                                perr_r <= 1'b1;
                                drop_r <= 1'b1;
                            end
                        end else begin
                            beat_r <= beat_r + CW'(1);
                            if (bus.rlast) begin
                                perr_r   <= 1'b1;
                                rready_r <= 1'b0;
                                state_r  <= S_ZFILL;
                            end
                        end
                    end
                end
                S_ZFILL: begin
                    wr_en_r   <= 1'b1;
                    wr_bank_r <= r_r;
                    wr_col_r  <= beat_r;
                    wr_data_r <= '0;
                    if (beat_last_s) begin
                        state_r <= S_NEXT;
                    end else begin
                        beat_r <= beat_r + CW'(1);
                    end
                end
                S_NEXT: begin
                    beat_r <= '0;
                    if (row_done_s) begin
                        r_r      <= 8'd0;
                        blkend_r <= 1'b1;
                        if (tx_last_s && ty_last_s) begin
                            mapend_r <= 1'b1;
                            tx_r     <= 16'd0;
                            ty_r     <= 16'd0;
                            state_r  <= S_IDLE;
                        end else if (tx_last_s) begin
                            tx_r    <= 16'd0;
                            ty_r    <= ty_r + 16'd1;
                            state_r <= S_HOLD;
                        end else begin
                            tx_r    <= tx_r + 16'd1;
                            state_r <= S_HOLD;
                        end
                    end else begin
                        r_r <= r_nxt_s;
                        if (row_in_map_f(ty_r, r_nxt_s)) begin
                            araddr_r  <= row_addr_f(base_r, tx_r, ty_r, r_nxt_s);
                            arvalid_r <= 1'b1;
                            state_r   <= S_ADDR;
                        end else begin
                            state_r <= S_ZFILL;
                        end
                    end
                end
                S_HOLD: begin
                    if (init_addr_en) begin
                        state_r <= S_IDLE;
                    end else if (data_load && !dl_prev_r) begin
                        state_r <= S_START;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.arvalid  = arvalid_r;
    assign bus.araddr   = araddr_r;
    assign bus.arlen    = 8'(BURST - 1);
    assign bus.arburst  = 2'b01;
    assign bus.rready   = rready_r;
    assign bus.wr_en    = wr_en_r;
    assign bus.wr_bank  = wr_bank_r;
    assign bus.wr_col   = wr_col_r;
    assign bus.wr_data  = wr_data_r;
    assign bus.blkend   = blkend_r;
    assign bus.mapend   = mapend_r;
    assign protocol_err = perr_r;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_r;
    logic        stall_s;

    assign stall_s = (arvalid_r && !bus.arready) || (rready_r && !bus.rvalid);

    // Saturating count of cycles the AXI side holds the fetch back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (init_ok_s) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif
endmodule

// File: tb/tb_ifmap_fetch_ctrl.sv
// Randomised scoreboard bench for ifmap_fetch_ctrl: a tile-level model predicts bursts and writes.
module tb_ifmap_fetch_ctrl;
    localparam int DW = 32, AW = 32, BURST = 32, CW = 5;
    localparam int TR = 7, CSTEP = 30, RSTEP = 6, IW = 224, IH = 224, NTX = 8, NTY = 38;

    typedef struct packed {
        logic [7:0]  bank;
        logic [4:0]  col;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int last_at;
        int ar_delay;
    } burst_t;

    logic          clk;
    logic          rst_n;
    logic          data_load;
    logic          init_addr_en;
    logic [AW-1:0] init_addr;
    logic          protocol_err;
`ifdef FETCH_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    ifmap_fetch_ctrl_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    ifmap_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_load    (data_load),
        .init_addr_en (init_addr_en),
        .init_addr    (init_addr),
        .bus          (bus),
        .protocol_err (protocol_err)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          blk_count = 0;
    int          ar_count = 0;
    bit          gap_en = 1'b0;
    logic [31:0] base_m = 32'h0;
    logic [31:0] exp_ar_q[$];
    wr_t         exp_wr_q[$];
    bit          exp_evt_q[$];
    burst_t      burst_q[$];
    logic [31:0] slave_data_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a tile is seven rows; rows inside the map read a burst, others are zero rows.
    task automatic plan_tile(input int tx, input int ty, input int early_row, input int ar_delay);
        int          row;
        int          last_at;
        logic [31:0] w;
        burst_t      bt;
        for (int r = 0; r < TR; r++) begin
            row = ty * RSTEP + r;
            if (row < IH) begin
                last_at = (r == early_row) ? 20 : BURST - 1;
                exp_ar_q.push_back(base_m + 32'((row * IW + tx * CSTEP) * 4));
                bt.last_at  = last_at;
                bt.ar_delay = (r == 0) ? ar_delay : 0;
                burst_q.push_back(bt);
                for (int b = 0; b < BURST; b++) begin
                    w = $urandom | 32'h1;
                    if (b <= last_at) slave_data_q.push_back(w);
                    exp_wr_q.push_back(wr_t'{8'(r), 5'(b),
                        ((b > last_at) || (tx * CSTEP + b >= IW)) ? 32'h0 : w});
                end
            end else begin
                for (int b = 0; b < BURST; b++) exp_wr_q.push_back(wr_t'{8'(r), 5'(b), 32'h0});
            end
        end
        exp_evt_q.push_back((tx == NTX - 1) && (ty == NTY - 1));
    endtask

    task automatic wait_blk(input int target);
        int n;
        n = 0;
        while (blk_count < target && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("blkend_timeout", 64'(blk_count >= target), 64'd1);
    endtask

    // AXI slave: serves planned bursts in order, with optional AR stall and R gaps.
    initial begin : slave
        bit     ar_hs, r_hs, ar_st, active;
        int     beat, last_at, stalled;
        burst_t cur;
        active = 1'b0; beat = 0; last_at = 0; stalled = 0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = bus.arvalid && bus.arready;
            r_hs  = bus.rvalid && bus.rready;
            ar_st = bus.arvalid && !bus.arready;
            @(posedge clk);
            #1;
            if (ar_hs && burst_q.size() > 0) begin
                cur = burst_q.pop_front();
                last_at = cur.last_at; active = 1'b1; beat = 0; stalled = 0;
            end else if (ar_st) begin
                stalled++;
            end
            if (r_hs && active) begin
                if (beat == last_at) active = 1'b0;
                beat++;
                if (slave_data_q.size() > 0) void'(slave_data_q.pop_front());
            end
            bus.arready = !active && (burst_q.size() > 0) && (stalled >= burst_q[0].ar_delay);
            if (active && slave_data_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                bus.rvalid = 1'b1;
                bus.rdata  = slave_data_q[0];
                bus.rlast  = (beat == last_at);
            end else begin
                bus.rvalid = 1'b0;
                bus.rdata  = '0;
                bus.rlast  = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an AR handshake, a write or an end pulse.
    initial begin : monitor
        logic [31:0] ar_addr_q;
        bit          ar_pend_q, prev_wr;
        logic [7:0]  prev_bank;
        logic [4:0]  prev_col;
        wr_t         e;
        ar_pend_q = 1'b0; prev_wr = 1'b0; prev_bank = '0; prev_col = '0; ar_addr_q = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ar_pend_q) begin
                    check("ar_hold_valid", 64'(bus.arvalid), 64'd1);
                    check("ar_hold_addr", 64'(bus.araddr), 64'(ar_addr_q));
                end
                if (bus.arvalid && bus.arready) begin
                    ar_count++;
                    check("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
                    if (exp_ar_q.size() != 0) check("araddr", 64'(bus.araddr), 64'(exp_ar_q.pop_front()));
                    check("arlen", 64'(bus.arlen), 64'd31);
                    check("arburst", 64'(bus.arburst), 64'd1);
                end
                ar_pend_q = bus.arvalid && !bus.arready;
                ar_addr_q = bus.araddr;
                if (bus.wr_en) begin
                    check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                    if (exp_wr_q.size() != 0) begin
                        e = exp_wr_q.pop_front();
                        check("wr_bank", 64'(bus.wr_bank), 64'(e.bank));
                        check("wr_col", 64'(bus.wr_col), 64'(e.col));
                        check("wr_data", 64'(bus.wr_data), 64'(e.data));
                    end
                end
                if (bus.blkend || bus.mapend) begin
                    check("blkend_with_mapend", 64'(bus.blkend), 64'd1);
                    check("evt_expected", 64'(exp_evt_q.size() != 0), 64'd1);
                    if (exp_evt_q.size() != 0) check("mapend", 64'(bus.mapend), 64'(exp_evt_q.pop_front()));
                    check("blk_after_last_wr", 64'({prev_wr, prev_bank, prev_col}), 64'({1'b1, 8'd6, 5'd31}));
                    check("tile_writes_done", 64'(exp_wr_q.size()), 64'd0);
                    blk_count++;
                end
                prev_wr   = bus.wr_en;
                prev_bank = bus.wr_bank;
                prev_col  = bus.wr_col;
            end
        end
    end

    initial begin : stim
        int          ar_before;
        logic [31:0] stall_before;
        rst_n = 1'b0; data_load = 1'b0; init_addr_en = 1'b0; init_addr = '0; stall_before = '0;
        repeat (3) @(negedge clk);
        check("rst_arvalid", 64'(bus.arvalid), 64'd0);
        check("rst_araddr", 64'(bus.araddr), 64'd0);
        check("rst_rready", 64'(bus.rready), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_wr_data", 64'(bus.wr_data), 64'd0);
        check("rst_ends", 64'({bus.blkend, bus.mapend, protocol_err}), 64'd0);
        check("rst_arlen", 64'(bus.arlen), 64'd31);
        check("rst_arburst", 64'(bus.arburst), 64'd1);
`ifdef FETCH_PERF_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        init_addr = 32'hA; init_addr_en = 1'b1;
        @(negedge clk);
        init_addr_en = 1'b0;
        base_m = 32'hA;
        for (int t = 0; t < NTX * NTY; t++) begin
            gap_en = (t >= 2 && t <= 5);
            plan_tile(t % NTX, t / NTX, -1, (t == 1) ? 5 : 0);
            ar_before = ar_count;
`ifdef FETCH_PERF_EN
            stall_before = stall_cnt;
`endif
            if (t != 0) @(negedge clk);
            data_load = 1'b1;
            wait_blk(t + 1);
            data_load = 1'b0;
`ifdef FETCH_PERF_EN
            if (t == 1) check("stall_delta", 64'(stall_cnt - stall_before), 64'd5);
`endif
            if (t / NTX == NTY - 1) check("last_row_ar_count", 64'(ar_count - ar_before), 64'd2);
        end
        gap_en = 1'b0;
        repeat (4) @(negedge clk);
        check("perr_clean_walk", 64'(protocol_err), 64'd0);
        check("idle_no_ar", 64'(bus.arvalid), 64'd0);
        // Restart from IDLE at tile (0,0) with a short burst on row 1.
        plan_tile(0, 0, 1, 0);
        data_load = 1'b1;
        wait_blk(NTX * NTY + 1);
        data_load = 1'b0;
        check("perr_early_rlast", 64'(protocol_err), 64'd1);
        init_addr_en = 1'b1;
        @(negedge clk);
        init_addr_en = 1'b0;
        check("perr_cleared", 64'(protocol_err), 64'd0);
`ifdef FETCH_PERF_EN
        check("stall_cleared", 64'(stall_cnt), 64'd0);
`endif
        repeat (3) @(negedge clk);
        check("ar_q_empty", 64'(exp_ar_q.size()), 64'd0);
        check("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
        check("evt_q_empty", 64'(exp_evt_q.size()), 64'd0);
        check("burst_q_empty", 64'(burst_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
